uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 9600, serial bit rate in bits/s.
REQ-002 SHALL have parameter CLOCK_FREQ, default 100_000_000, clk frequency in Hz.
REQ-003 SHALL derive localparam BIT_PERIOD = CLOCK_FREQ / BAUD_RATE (integer divide; 10416 at defaults) and HALF_PERIOD = BIT_PERIOD / 2.
REQ-004 SHALL have port clk, input, 1, system clock; all logic on its rising edge, single clock domain.
REQ-005 SHALL have port reset, input, 1, synchronous active-low reset, sampled only on a clk rising edge.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line, idle high, 8N1 LSB-first.
REQ-007 SHALL have port rx_ack, input, 1, consumer acknowledge of the held byte.
REQ-008 SHALL have port rx_data, output, 8, last correctly framed byte.
REQ-009 SHALL have port rx_valid, output, 1, high while rx_data holds an unacknowledged byte.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overrun, output, 1, sticky flag: a byte arrived while rx_valid was high.
REQ-012 SHALL have port rx_busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL pass rx through a two-flop synchronizer (reset value 1 for both flops); all decisions use the second flop (rx_s); the sync adds 2 cycles of latency.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP with a 16-bit clk_count, 3-bit bit_index and 8-bit shift_reg.
REQ-015 IDLE: clk_count=0, bit_index=0; on rx_s==0, go to START.
REQ-016 START: increment clk_count; at clk_count==HALF_PERIOD-1, if rx_s==0 then clk_count<=0 and go to DATA, else return to IDLE (glitch reject, no flags).
REQ-017 DATA: increment clk_count; at clk_count==BIT_PERIOD-1, set clk_count<=0, shift_reg<={rx_s, shift_reg[7:1]}, bit_index++; after the sample taken with bit_index==7, go to STOP.
REQ-018 STOP: increment clk_count; at clk_count==BIT_PERIOD-1, sample rx_s, clk_count<=0, go to IDLE.
REQ-019 STOP sample ==1 with rx_valid==0 (after rx_ack handling in that same cycle): rx_data<=shift_reg, rx_valid<=1 on the next edge.
REQ-020 STOP sample ==1 with rx_valid==1 and no rx_ack that cycle: overrun<=1, rx_data and rx_valid unchanged, new byte discarded.
REQ-021 STOP sample ==0: frame_err high for exactly one cycle, byte discarded, rx_data/rx_valid unchanged.
REQ-022 rx_ack while rx_valid==1 SHALL clear rx_valid on the next edge; rx_ack while rx_valid==0 SHALL be ignored.
REQ-023 rx_ack and a valid stop sample in the same cycle: new byte loaded, rx_valid stays 1, no overrun.
REQ-024 overrun SHALL clear only on reset.
REQ-025 A stop-bit sample of 1 followed immediately by a new falling edge SHALL be accepted (back-to-back frames, no idle gap required beyond the stop bit).
REQ-026 Sampling points: start at mid-bit, data/stop bits at BIT_PERIOD intervals thereafter, i.e. nominally mid-bit.
REQ-027 BIT_PERIOD SHALL be within 4..65535; values outside are unsupported.

Reset
REQ-028 reset==0 at a clk edge: state IDLE, clk_count=0, bit_index=0, shift_reg=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, rx_busy=0, sync flops=1.
REQ-029 reset asserted mid-frame SHALL abandon the frame without raising any flag; after release, the FSM waits for the next falling edge of rx_s.

Verification (BAUD_RATE=6_250_000, CLOCK_FREQ=100_000_000 -> BIT_PERIOD=16)
REQ-030 Send 0xA5 8N1 at 16 clk/bit -> rx_valid rises, rx_data=0xA5, frame_err=0; rx_ack -> rx_valid=0 next cycle.
REQ-031 Low pulse of 4 cycles on idle rx -> FSM returns to IDLE from START, rx_valid=0, frame_err=0.
REQ-032 Send 0x3C with stop bit driven 0 -> frame_err one-cycle pulse, rx_valid=0, rx_data unchanged.
REQ-033 Send 0x11 then 0x22 back-to-back without rx_ack -> rx_data=0x11, rx_valid=1, overrun=1; repeat with rx_ack coincident with the second stop sample -> rx_data=0x22, overrun=0.
REQ-034 Assert reset during bit 3 of 0xFF, release, send 0x5A -> all outputs at reset values, then rx_data=0x5A, rx_valid=1.
REQ-035 Loopback from the existing transmitter (tx_data=0x81, same parameters) -> rx_data=0x81, rx_valid=1, no flags.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 LSB-first UART receiver with mid-bit sampling, holding
//             register with ack handshake, frame-error pulse, sticky overrun.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_FREQ = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int BIT_PERIOD  = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_PERIOD = BIT_PERIOD / 2;

    localparam logic [15:0] c_bit_last  = 16'(BIT_PERIOD - 1);
    localparam logic [15:0] c_half_last = 16'(HALF_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic [15:0] clk_count_q, clk_count_d;
    logic [2:0]  bit_index_q, bit_index_d;
    logic [7:0]  shift_reg_q, shift_reg_d;
    logic [7:0]  rx_data_q,   rx_data_d;
    logic        rx_valid_q,  rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q,   overrun_d;
    logic        rx_meta_q,   rx_meta_d;
    logic        rx_s_q,      rx_s_d;

    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q;
        bit_index_d = bit_index_q;
        shift_reg_d = shift_reg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;

        // Ack is resolved first so a stop sample in the same cycle sees a free slot.
        if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                clk_count_d = 16'd0;
                bit_index_d = 3'd0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (clk_count_q == c_half_last) begin
                    clk_count_d = 16'd0;
                    state_d     = rx_s_q ? IDLE : DATA;
                end else begin
                    clk_count_d = clk_count_q + 16'd1;
                end
            end
            DATA: begin
                if (clk_count_q == c_bit_last) begin
                    clk_count_d = 16'd0;
                    shift_reg_d = {rx_s_q, shift_reg_q[7:1]};
                    bit_index_d = bit_index_q + 3'd1;
                    if (bit_index_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    clk_count_d = clk_count_q + 16'd1;
                end
            end
            STOP: begin
                if (clk_count_q == c_bit_last) begin
                    clk_count_d = 16'd0;
                    state_d     = IDLE;
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                    end else if (!rx_valid_d) begin
                        rx_data_d  = shift_reg_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    clk_count_d = clk_count_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            clk_count_q <= 16'd0;
            bit_index_q <= 3'd0;
            shift_reg_q <= 8'd0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            clk_count_q <= clk_count_d;
            bit_index_q <= bit_index_d;
            shift_reg_q <= shift_reg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_busy   = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Directed table-driven bench for uart_rx at 16 clk per bit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int BIT = 16;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       rx     = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int fe_total = 0;
    int busy_total = 0;

    uart_rx #(
        .BAUD_RATE (6_250_000),
        .CLOCK_FREQ(100_000_000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rx_ack   (rx_ack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_total++;
        if (rx_busy)   busy_total++;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ack_stop;
        logic       ack_after;
        logic [7:0] exp_data;
        logic       exp_valid;
        int         exp_fe;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx     = 1'b1;
            rx_ack = 1'b0;
        end
    endtask

    // One full frame, 10 bits x BIT cycles; the receiver samples the stop bit
    // on the edge after iteration 154, so an ack there coincides with it.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic ack_stop);
        logic [9:0] frame;
        frame = {stop_bit, data, 1'b0};
        for (int c = 0; c < 10 * BIT; c++) begin
            @(posedge clk); #1;
            rx     = frame[c / BIT];
            rx_ack = ack_stop && (c == 154);
        end
        rx_ack = 1'b0;
    endtask

    task automatic ack_pulse();
        @(posedge clk); #1;
        rx_ack = 1'b1;
        @(posedge clk); #1;
        rx_ack = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " rx_data"},   32'(rx_data),   32'h00);
        check({tag, " rx_valid"},  32'(rx_valid),  32'h0);
        check({tag, " frame_err"}, 32'(frame_err), 32'h0);
        check({tag, " overrun"},   32'(overrun),   32'h0);
        check({tag, " rx_busy"},   32'(rx_busy),   32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_state("reset");
        reset = 1'b1;
        idle(4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int fe0;
        int b0;

        //            data   stop  ackS  ackA  exp_d  v    fe  ovr
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1, 1'b0};
        vecs[2] = '{8'h81, 1'b1, 1'b0, 1'b1, 8'h81, 1'b1, 0, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 0, 1'b0};
        vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1, 1'b0};
        vecs[6] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 0, 1'b1};

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("init");
        reset = 1'b1;
        idle(10);

        for (int i = 0; i < 7; i++) begin
            fe0 = fe_total;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].ack_stop);
            check($sformatf("vec%0d rx_data", i),   32'(rx_data),       32'(vecs[i].exp_data));
            check($sformatf("vec%0d rx_valid", i),  32'(rx_valid),      32'(vecs[i].exp_valid));
            check($sformatf("vec%0d frame_err", i), 32'(fe_total - fe0), 32'(vecs[i].exp_fe));
            check($sformatf("vec%0d overrun", i),   32'(overrun),       32'(vecs[i].exp_ovr));
            if (vecs[i].ack_after) begin
                ack_pulse();
                check($sformatf("vec%0d ack clears valid", i), 32'(rx_valid), 32'h0);
            end
            idle(24);
        end

        // Overrun is sticky, so it must still be set before the reset clears it.
        do_reset();

        // Back-to-back frames without ack: first byte kept, overrun raised.
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        check("b2b rx_data",  32'(rx_data),  32'h11);
        check("b2b rx_valid", 32'(rx_valid), 32'h1);
        check("b2b overrun",  32'(overrun),  32'h1);
        idle(24);

        // Reset partway through bit 3 of 0xFF abandons the frame silently.
        fe0 = fe_total;
        for (int c = 0; c < 4 * BIT + 8; c++) begin
            @(posedge clk); #1;
            rx = (c < BIT) ? 1'b0 : 1'b1;
        end
        check("midframe busy", 32'(rx_busy), 32'h1);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_reset_state("midframe reset");
        reset = 1'b1;
        idle(6 * BIT);
        check("midframe no flag", 32'(fe_total - fe0), 32'h0);
        check("midframe idle",    32'(rx_busy),        32'h0);
        send_frame(8'h5A, 1'b1, 1'b0);
        check("after reset rx_data",  32'(rx_data),  32'h5A);
        check("after reset rx_valid", 32'(rx_valid), 32'h1);
        check("after reset overrun",  32'(overrun),  32'h0);
        idle(24);

        // Ack coincident with the second stop sample: new byte taken, no overrun.
        do_reset();
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        check("b2b ack rx_data",  32'(rx_data),  32'h22);
        check("b2b ack rx_valid", 32'(rx_valid), 32'h1);
        check("b2b ack overrun",  32'(overrun),  32'h0);
        idle(24);
        ack_pulse();
        check("b2b ack clears valid", 32'(rx_valid), 32'h0);

        // Four-cycle low glitch is rejected in START.
        fe0 = fe_total;
        b0  = busy_total;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            rx = 1'b0;
        end
        idle(40);
        check("glitch rx_valid",  32'(rx_valid),              32'h0);
        check("glitch frame_err", 32'(fe_total - fe0),        32'h0);
        check("glitch saw busy",  32'(busy_total != b0),      32'h1);
        check("glitch idle",      32'(rx_busy),               32'h0);
        check("glitch rx_data",   32'(rx_data),               32'h22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
